al4s3b_wb_master: RTL and testbench
===================================

# al4s3b_wb_master

Wishbone initiator that turns single-beat register requests from a local requester into Wishbone read/write cycles toward FPGA register slaves. Drives CYC/STB/WE/BYTE_STB/ADR/DAT, waits for ACK, returns read data or an error response. An optional bus-timeout watchdog covers unresponsive slaves. Sits between a host-side command source (UART/SPI command decoder, test sequencer) and the fabric register map.

## Interface
Parameters:
- ADDRWIDTH, 10, byte-address width of requests and of WBm_ADR_o
- DATAWIDTH, 32, data width
- TIMEOUT_CYCLES, 16, STB-high cycles without ACK before timeout error (≥2; used only with WBM_TIMEOUT_EN)
- ERR_DATA, 32'hFABDEFAC, rsp_dat_o value on timeout

Ports:
- WBs_CLK_i  in  1  clock; everything is on the rising edge
- WBs_RST_i  in  1  synchronous, active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when req_valid_i & req_ready_o
- req_we_i  in  1  1 = write, 0 = read
- req_adr_i  in  ADDRWIDTH  byte address; bits [1:0] ignored
- req_sel_i  in  4  byte strobes
- req_dat_i  in  DATAWIDTH  write data
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed when rsp_valid_o & rsp_ready_i
- rsp_dat_o  out  DATAWIDTH  read data (0 for writes; ERR_DATA on timeout)
- rsp_err_o  out  1  timeout flag
- WBm_ADR_o  out  ADDRWIDTH  word address {2'b00, req_adr_i[ADDRWIDTH-1:2]}
- WBm_CYC_o, WBm_STB_o, WBm_WE_o  out  1  Wishbone controls
- WBm_BYTE_STB_o  out  4  byte selects
- WBm_DAT_o  out  DATAWIDTH  write data
- WBm_DAT_i  in  DATAWIDTH  read data
- WBm_ACK_i  in  1  slave acknowledge

## Operation
- FSM: IDLE, BUS, RESP.
- IDLE: req_ready_o=1. On handshake, latch we/adr/sel/dat into the bus output registers, set CYC=STB=1, go to BUS.
- BUS: hold all bus outputs stable. On the edge where WBm_ACK_i=1:
  - clear CYC/STB/WE.
  - For a read, capture WBm_DAT_i into rsp_dat_o; for a write, load 0.
  - Set rsp_err_o=0 and rsp_valid_o=1, go to RESP.
- Timeout in BUS (macro on): the watchdog counter increments every BUS cycle without ACK. On the edge where it reaches TIMEOUT_CYCLES-1 with no ACK:
  - clear CYC/STB.
  - Set rsp_dat_o=ERR_DATA, rsp_err_o=1 and rsp_valid_o=1, go to RESP.
  - ACK on that same edge wins: normal response.
- RESP: hold the response until rsp_ready_i=1, then clear rsp_valid_o and go to IDLE. req_ready_o=0 outside IDLE, so exactly one transaction is outstanding.
- Address/data/sel outputs keep their last value when idle. Only CYC/STB/WE return to 0.
- ACK outside BUS is ignored.

## Timing
- Reset values: req_ready_o=0 during reset, 1 from the first cycle after release. rsp_valid_o=0, rsp_err_o=0, rsp_dat_o=0, all WBm_* outputs=0, counter=0, FSM=IDLE.
- Reset asserted mid-BUS or mid-RESP: all of the above apply on the next edge. The bus cycle and any pending response are dropped.
- Request handshake at edge N → CYC/STB high in cycle N+1.
- With a slave that registers ACK one cycle after STB: ACK is visible in N+2, STB drops and data is captured at edge N+3, rsp_valid_o is high from N+3.
- Minimum request-to-response latency: 3 cycles. Next request can be accepted at the edge where the response is consumed +1 (IDLE cycle).
- All outputs are registered. No combinational path from WBm_ACK_i or rsp_ready_i to any output.
- Counter width is clog2(TIMEOUT_CYCLES). It saturates and clears on leaving BUS.

## Configuration
- WBM_TIMEOUT_EN defined: watchdog present as above.
- Not defined: no counter; BUS waits indefinitely for ACK; rsp_err_o is tied to 0; TIMEOUT_CYCLES and ERR_DATA are unused.

## Structure
- Shared package al4s3b_wb_pkg:
  - FSM state encoding (IDLE=2'd0, BUS=2'd1, RESP=2'd2)
  - default ERR_DATA constant 32'hFABDEFAC
  - Wishbone word-address shift constant (2)
- One sub-module, al4s3b_wb_timeout: clear/enable/expire watchdog counter, instantiated only under WBM_TIMEOUT_EN.

## Test plan
- Write: req adr 10'h00C, dat 32'h0000_0003, sel 4'hF, against a register slave → one CYC/STB pulse 2 cycles long, WBm_ADR_o=10'h003, WE=1; response rsp_dat_o=0, rsp_err_o=0, 3 cycles after the handshake.
- Read: adr 10'h000 from a slave returning 32'hABCD0001 → rsp_dat_o=32'hABCD0001, rsp_err_o=0; adr 10'h3F0 → 32'hFABDEFAC, rsp_err_o=0.
- Timeout (macro on, TIMEOUT_CYCLES=16), slave never ACKs → STB high exactly 16 cycles, then rsp_err_o=1, rsp_dat_o=32'hFABDEFAC; macro off → STB stays high for 100+ cycles.
- Backpressure: rsp_ready_i low for 5 cycles after a read → rsp_valid_o/rsp_dat_o stable, req_ready_o=0, no new CYC; the next request is accepted one cycle after consume.
- Reset mid-BUS: WBs_RST_i=0 for 1 cycle while STB is high → next edge all WBm_*=0, rsp_valid_o=0; after release, a new read completes normally.
- Back-to-back: 4 requests with req_valid_i held high and rsp_ready_i=1 → 4 responses in order, no overlapping CYC pulses, each CYC pulse followed by ≥1 cycle with CYC low before the next.

Source files
------------

// File: rtl/al4s3b_wb_pkg.sv
// Shared state encoding and constants for the AL4S3B Wishbone initiator.
package al4s3b_wb_pkg;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_BUS  = 2'd1,
        WB_RESP = 2'd2
    } wb_state_e;

    localparam logic [31:0] WB_ERR_DATA_DEFAULT = 32'hFABDEFAC;
    localparam int unsigned WB_ADR_SHIFT        = 2;

endpackage

// File: rtl/al4s3b_wb_timeout.sv
// Saturating bus watchdog: counts enabled cycles, flags the final allowed cycle.
module al4s3b_wb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == CNT_LAST);

endmodule

// File: rtl/al4s3b_wb_master.sv
// Single-outstanding Wishbone initiator for local register requests.
// Define WBM_TIMEOUT_EN to add the bus-timeout watchdog.
module al4s3b_wb_master
    import al4s3b_wb_pkg::*;
#(
    parameter int unsigned ADDRWIDTH      = 10,
    parameter int unsigned DATAWIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = WB_ERR_DATA_DEFAULT
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_we_i,
    input  logic [ADDRWIDTH-1:0] req_adr_i,
    input  logic [3:0]           req_sel_i,
    input  logic [DATAWIDTH-1:0] req_dat_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [DATAWIDTH-1:0] rsp_dat_o,
    output logic                 rsp_err_o,
    output logic [ADDRWIDTH-1:0] WBm_ADR_o,
    output logic                 WBm_CYC_o,
    output logic                 WBm_STB_o,
    output logic                 WBm_WE_o,
    output logic [3:0]           WBm_BYTE_STB_o,
    output logic [DATAWIDTH-1:0] WBm_DAT_o,
    input  logic [DATAWIDTH-1:0] WBm_DAT_i,
    input  logic                 WBm_ACK_i
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    wb_state_e            state_q, state_d;
    logic                 req_ready_q, req_ready_d;
    logic                 cyc_q, cyc_d;
    logic                 we_q, we_d;
    logic [3:0]           sel_q, sel_d;
    logic [ADDRWIDTH-1:0] adr_q, adr_d;
    logic [DATAWIDTH-1:0] dat_q, dat_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATAWIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic                 rsp_err_q, rsp_err_d;
    logic                 req_fire;
    logic                 timeout_hit;

    assign req_fire = req_valid_i & req_ready_q;

`ifdef WBM_TIMEOUT_EN
    logic to_expired;

    al4s3b_wb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (WBs_CLK_i),
        .rst_n    (WBs_RST_i),
        .clear_i  (state_q != WB_BUS),
        .enable_i ((state_q == WB_BUS) && !WBm_ACK_i),
        .expired_c(to_expired)
    );

    // An ACK on the expiry edge still completes normally.
    assign timeout_hit = (state_q == WB_BUS) && !WBm_ACK_i && to_expired;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            WB_IDLE: begin
                if (req_fire) begin
                    state_d = WB_BUS;
                    cyc_d   = 1'b1;
                    we_d    = req_we_i;
                    sel_d   = req_sel_i;
                    adr_d   = ADDRWIDTH'(req_adr_i >> WB_ADR_SHIFT);
                    dat_d   = req_dat_i;
                end
            end
            WB_BUS: begin
                if (WBm_ACK_i) begin
                    rsp_dat_d = we_q ? '0 : WBm_DAT_i;
                    rsp_err_d = 1'b0;
                end else if (timeout_hit) begin
                    rsp_dat_d = DATAWIDTH'(ERR_DATA);
                    rsp_err_d = 1'b1;
                end
                if (WBm_ACK_i || timeout_hit) begin
                    state_d     = WB_RESP;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                end
            end
            WB_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = WB_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = WB_IDLE;
        endcase
        req_ready_d = (state_d == WB_IDLE);
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (!WBs_RST_i) begin
            state_q     <= WB_IDLE;
            req_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready_o    = req_ready_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_dat_o      = rsp_dat_q;
    assign rsp_err_o      = rsp_err_q;
    assign WBm_ADR_o      = adr_q;
    assign WBm_CYC_o      = cyc_q;
    assign WBm_STB_o      = cyc_q;
    assign WBm_WE_o       = we_q;
    assign WBm_BYTE_STB_o = sel_q;
    assign WBm_DAT_o      = dat_q;

endmodule

// File: tb/tb_al4s3b_wb_master.sv
// Self-checking bench for al4s3b_wb_master with a register-slave model.
module tb_al4s3b_wb_master;

    localparam int TO_CYCLES = 16;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [9:0]  req_adr_i;
    logic [3:0]  req_sel_i;
    logic [31:0] req_dat_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [31:0] rsp_dat_o;
    logic [9:0]  WBm_ADR_o;
    logic        WBm_CYC_o, WBm_STB_o, WBm_WE_o;
    logic [3:0]  WBm_BYTE_STB_o;
    logic [31:0] WBm_DAT_o;
    logic [31:0] slv_rdat;
    logic        slv_ack;

    int vectors = 0;
    int miscompares = 0;

    al4s3b_wb_master dut (
        .WBs_CLK_i(clk), .WBs_RST_i(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_adr_i(req_adr_i), .req_sel_i(req_sel_i), .req_dat_i(req_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o), .WBm_ADR_o(WBm_ADR_o), .WBm_CYC_o(WBm_CYC_o),
        .WBm_STB_o(WBm_STB_o), .WBm_WE_o(WBm_WE_o), .WBm_BYTE_STB_o(WBm_BYTE_STB_o),
        .WBm_DAT_o(WBm_DAT_o), .WBm_DAT_i(slv_rdat), .WBm_ACK_i(slv_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        if (i == 0)     return 32'hABCD0001;
        if (i == 'hFC)  return 32'hFABDEFAC;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Register slave: ACK registered ack_delay+1 edges after STB is first seen.
    logic [31:0] slave_mem [256];
    bit          init_done;
    bit          slave_en;
    int          ack_delay;
    int          wait_cnt;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) slave_mem[i] <= init_word(i);
            init_done <= 1'b1;
            slv_ack   <= 1'b0;
            slv_rdat  <= '0;
            wait_cnt  <= 0;
        end else if (slave_en && WBm_CYC_o && WBm_STB_o && !slv_ack) begin
            if (wait_cnt >= ack_delay) begin
                slv_ack  <= 1'b1;
                wait_cnt <= 0;
                if (WBm_WE_o)
                    slave_mem[WBm_ADR_o[7:0]] <= merge(slave_mem[WBm_ADR_o[7:0]], WBm_DAT_o, WBm_BYTE_STB_o);
                else
                    slv_rdat <= slave_mem[WBm_ADR_o[7:0]];
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            slv_ack  <= 1'b0;
            wait_cnt <= 0;
        end
    end

    // Reference register map: writes merge by byte strobe and answer 0, reads return the word.
    logic [31:0] ref_mem [256];

    function automatic logic [31:0] model_rsp(bit we, logic [9:0] adr, logic [3:0] sel, logic [31:0] dat);
        logic [7:0] w;
        w = adr[9:2];
        if (we) begin
            ref_mem[w] = merge(ref_mem[w], dat, sel);
            return 32'h0;
        end
        return ref_mem[w];
    endfunction

    typedef struct {
        logic [31:0] rsp_dat;
        logic        rsp_err;
        int          lat;
        int          stb_len;
        int          wait_n;
        logic [9:0]  adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        bit          stable;
        bit          ready_low;
        bit          consumed;
        logic        cyc_resp;
        logic        idle_cyc;
        logic [9:0]  adr_after;
        logic        we_after;
    } obs_t;

    // Drives one request and records what the DUT does; comparisons are done by callers.
    task automatic do_txn(input bit we, input logic [9:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input int hold, input int budget,
                          input bit keep_valid, output obs_t o);
        req_we_i = we; req_adr_i = adr; req_sel_i = sel; req_dat_i = dat;
        req_valid_i = 1'b1;
        rsp_ready_i = (hold == 0);
        o.wait_n = 0;
        while (req_ready_o !== 1'b1 && o.wait_n < 40) begin
            @(posedge clk); #1; o.wait_n++;
        end
        @(posedge clk); #1;
        if (!keep_valid) req_valid_i = 1'b0;
        o.adr = WBm_ADR_o; o.we = WBm_WE_o; o.sel = WBm_BYTE_STB_o; o.dat = WBm_DAT_o;
        o.stable = 1'b1; o.ready_low = 1'b1; o.stb_len = 0; o.lat = 1;
        while (rsp_valid_o !== 1'b1 && o.lat < budget) begin
            if (WBm_STB_o === 1'b1) begin
                o.stb_len++;
                if (WBm_ADR_o !== o.adr || WBm_WE_o !== o.we || WBm_BYTE_STB_o !== o.sel ||
                    WBm_DAT_o !== o.dat || WBm_CYC_o !== 1'b1) o.stable = 1'b0;
            end
            if (req_ready_o !== 1'b0) o.ready_low = 1'b0;
            @(posedge clk); #1; o.lat++;
        end
        o.rsp_dat = rsp_dat_o; o.rsp_err = rsp_err_o; o.cyc_resp = WBm_CYC_o;
        for (int i = 0; i < hold; i++) begin
            if (rsp_valid_o !== 1'b1 || rsp_dat_o !== o.rsp_dat || rsp_err_o !== o.rsp_err ||
                WBm_CYC_o !== 1'b0) o.stable = 1'b0;
            if (req_ready_o !== 1'b0) o.ready_low = 1'b0;
            @(posedge clk); #1;
        end
        rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        o.consumed  = (rsp_valid_o === 1'b0) && (req_ready_o === 1'b1);
        o.idle_cyc  = WBm_CYC_o;
        o.adr_after = WBm_ADR_o;
        o.we_after  = WBm_WE_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_BYTE_STB_o, WBm_ADR_o, WBm_DAT_o} !== '0) begin
            miscompares++; $display("FAIL reset_bus got cyc=%b adr=%h dat=%h exp all 0", WBm_CYC_o, WBm_ADR_o, WBm_DAT_o);
        end
        vectors++;
        if ({rsp_valid_o, rsp_err_o, rsp_dat_o} !== '0) begin
            miscompares++; $display("FAIL reset_rsp got valid=%b err=%b dat=%h exp 0", rsp_valid_o, rsp_err_o, rsp_dat_o);
        end
        vectors++;
        if (req_ready_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_ready_low got=%b exp=0", req_ready_o);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (req_ready_o !== 1'b1) begin
            miscompares++; $display("FAIL reset_ready_release got=%b exp=1", req_ready_o);
        end
    endtask

    task automatic test_write();
        obs_t o; logic [31:0] exp;
        slave_en = 1'b1; ack_delay = 0;
        exp = model_rsp(1'b1, 10'h00C, 4'hF, 32'h0000_0003);
        do_txn(1'b1, 10'h00C, 4'hF, 32'h0000_0003, 0, 30, 1'b0, o);
        vectors++;
        if (o.stb_len !== 2) begin miscompares++; $display("FAIL write_stb_len got=%0d exp=2", o.stb_len); end
        vectors++;
        if (o.lat !== 3) begin miscompares++; $display("FAIL write_latency got=%0d exp=3", o.lat); end
        vectors++;
        if (o.adr !== 10'h003 || o.we !== 1'b1 || o.sel !== 4'hF || o.dat !== 32'h3) begin
            miscompares++; $display("FAIL write_bus got adr=%h we=%b sel=%h dat=%h exp 003/1/f/3", o.adr, o.we, o.sel, o.dat);
        end
        vectors++;
        if (o.rsp_dat !== exp || o.rsp_err !== 1'b0) begin
            miscompares++; $display("FAIL write_rsp got dat=%h err=%b exp dat=%h err=0", o.rsp_dat, o.rsp_err, exp);
        end
        vectors++;
        if (o.adr_after !== 10'h003 || o.we_after !== 1'b0 || o.idle_cyc !== 1'b0) begin
            miscompares++; $display("FAIL write_idle_hold got adr=%h we=%b cyc=%b exp 003/0/0", o.adr_after, o.we_after, o.idle_cyc);
        end
    endtask

    task automatic test_read();
        obs_t o; logic [31:0] exp;
        exp = model_rsp(1'b0, 10'h000, 4'hF, 32'h0);
        do_txn(1'b0, 10'h000, 4'hF, 32'h0, 0, 30, 1'b0, o);
        vectors++;
        if (o.rsp_dat !== 32'hABCD0001 || o.rsp_dat !== exp || o.rsp_err !== 1'b0) begin
            miscompares++; $display("FAIL read_000 got dat=%h err=%b exp abcd0001/0", o.rsp_dat, o.rsp_err);
        end
        do_txn(1'b0, 10'h3F0, 4'hF, 32'h0, 0, 30, 1'b0, o);
        vectors++;
        if (o.rsp_dat !== 32'hFABDEFAC || o.rsp_err !== 1'b0 || o.adr !== 10'h0FC) begin
            miscompares++; $display("FAIL read_3f0 got dat=%h err=%b adr=%h exp fabdefac/0/0fc", o.rsp_dat, o.rsp_err, o.adr);
        end
    endtask

    task automatic test_backpressure();
        obs_t o; logic [31:0] exp;
        exp = model_rsp(1'b0, 10'h00C, 4'hF, 32'h0);
        do_txn(1'b0, 10'h00C, 4'hF, 32'h0, 5, 30, 1'b0, o);
        vectors++;
        if (o.stable !== 1'b1 || o.ready_low !== 1'b1 || o.consumed !== 1'b1) begin
            miscompares++; $display("FAIL bp_hold got stable=%b ready_low=%b consumed=%b exp 1/1/1", o.stable, o.ready_low, o.consumed);
        end
        vectors++;
        if (o.rsp_dat !== exp) begin miscompares++; $display("FAIL bp_data got=%h exp=%h", o.rsp_dat, exp); end
        exp = model_rsp(1'b1, 10'h010, 4'h5, 32'h1234_5678);
        do_txn(1'b1, 10'h010, 4'h5, 32'h1234_5678, 0, 30, 1'b0, o);
        vectors++;
        if (o.wait_n !== 0 || o.lat !== 3) begin
            miscompares++; $display("FAIL bp_next_accept got wait=%0d lat=%0d exp 0/3", o.wait_n, o.lat);
        end
    endtask

    task automatic test_timeout();
        obs_t o; logic [31:0] exp;
`ifdef WBM_TIMEOUT_EN
        slave_en = 1'b0;
        do_txn(1'b0, 10'h020, 4'hF, 32'h0, 0, 40, 1'b0, o);
        vectors++;
        if (o.stb_len !== TO_CYCLES || o.lat !== TO_CYCLES + 1) begin
            miscompares++; $display("FAIL timeout_len got stb=%0d lat=%0d exp %0d/%0d", o.stb_len, o.lat, TO_CYCLES, TO_CYCLES + 1);
        end
        vectors++;
        if (o.rsp_err !== 1'b1 || o.rsp_dat !== 32'hFABDEFAC) begin
            miscompares++; $display("FAIL timeout_rsp got err=%b dat=%h exp 1/fabdefac", o.rsp_err, o.rsp_dat);
        end
        slave_en = 1'b1; ack_delay = TO_CYCLES - 2;
        exp = model_rsp(1'b0, 10'h000, 4'hF, 32'h0);
        do_txn(1'b0, 10'h000, 4'hF, 32'h0, 0, 40, 1'b0, o);
        vectors++;
        if (o.rsp_err !== 1'b0 || o.rsp_dat !== exp || o.stb_len !== TO_CYCLES) begin
            miscompares++; $display("FAIL timeout_ack_wins got err=%b dat=%h stb=%0d exp 0/%h/%0d", o.rsp_err, o.rsp_dat, o.stb_len, exp, TO_CYCLES);
        end
`else
        slave_en = 1'b1; ack_delay = 20;
        exp = model_rsp(1'b0, 10'h000, 4'hF, 32'h0);
        do_txn(1'b0, 10'h000, 4'hF, 32'h0, 0, 60, 1'b0, o);
        vectors++;
        if (o.rsp_err !== 1'b0 || o.rsp_dat !== exp || o.stb_len !== 22) begin
            miscompares++; $display("FAIL slow_ack got err=%b dat=%h stb=%0d exp 0/%h/22", o.rsp_err, o.rsp_dat, o.stb_len, exp);
        end
`endif
        ack_delay = 0; slave_en = 1'b1;
    endtask

    task automatic test_reset_mid_bus();
        obs_t o; logic [31:0] exp; int n; int stb_cnt; int wait_len;
`ifdef WBM_TIMEOUT_EN
        wait_len = 3;
`else
        wait_len = 120;
`endif
        slave_en = 1'b0; rsp_ready_i = 1'b1;
        req_we_i = 1'b0; req_adr_i = 10'h024; req_sel_i = 4'hF; req_dat_i = $urandom | 32'h1;
        req_valid_i = 1'b1;
        n = 0;
        while (req_ready_o !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        stb_cnt = 0;
        for (int i = 0; i < wait_len; i++) begin
            if (WBm_STB_o === 1'b1 && WBm_CYC_o === 1'b1) stb_cnt++;
            @(posedge clk); #1;
        end
        vectors++;
        if (stb_cnt !== wait_len) begin miscompares++; $display("FAIL stb_wait got=%0d exp=%0d", stb_cnt, wait_len); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({WBm_CYC_o, WBm_STB_o, WBm_WE_o, WBm_BYTE_STB_o, WBm_ADR_o, WBm_DAT_o} !== '0 ||
            rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
            miscompares++; $display("FAIL midbus_reset got cyc=%b adr=%h dat=%h rv=%b rdy=%b exp all 0", WBm_CYC_o, WBm_ADR_o, WBm_DAT_o, rsp_valid_o, req_ready_o);
        end
        rst_n = 1'b1; slave_en = 1'b1;
        @(posedge clk); #1;
        exp = model_rsp(1'b0, 10'h3F0, 4'hF, 32'h0);
        do_txn(1'b0, 10'h3F0, 4'hF, 32'h0, 1, 30, 1'b0, o);
        vectors++;
        if (o.rsp_dat !== exp || o.rsp_err !== 1'b0 || o.lat !== 3 || o.wait_n !== 0) begin
            miscompares++; $display("FAIL midbus_recover got dat=%h err=%b lat=%0d wait=%0d exp %h/0/3/0", o.rsp_dat, o.rsp_err, o.lat, o.wait_n, exp);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o; logic [31:0] exp; bit we; logic [9:0] a; logic [3:0] s; logic [31:0] d;
        for (int k = 0; k < 4; k++) begin
            we = (k % 2 == 0);
            a  = (k < 2) ? 10'h040 : 10'h084;
            s  = 4'($urandom);
            d  = $urandom;
            exp = model_rsp(we, a, s, d);
            do_txn(we, a, s, d, 0, 30, (k < 3), o);
            vectors++;
            if (o.rsp_dat !== exp || o.lat !== 3 || o.wait_n !== 0) begin
                miscompares++; $display("FAIL b2b_%0d got dat=%h lat=%0d wait=%0d exp %h/3/0", k, o.rsp_dat, o.lat, o.wait_n, exp);
            end
            vectors++;
            if (o.cyc_resp !== 1'b0 || o.idle_cyc !== 1'b0) begin
                miscompares++; $display("FAIL b2b_gap_%0d got cyc_resp=%b cyc_idle=%b exp 0/0", k, o.cyc_resp, o.idle_cyc);
            end
        end
        req_valid_i = 1'b0;
    endtask

    task automatic test_random();
        obs_t o; logic [31:0] exp; bit we; logic [9:0] a; logic [3:0] s; logic [31:0] d; int hold;
        for (int k = 0; k < 24; k++) begin
            we   = 1'($urandom_range(0, 1));
            a    = 10'($urandom);
            s    = 4'($urandom);
            d    = $urandom;
            hold = $urandom_range(0, 3);
            exp  = model_rsp(we, a, s, d);
            do_txn(we, a, s, d, hold, 30, 1'b0, o);
            vectors++;
            if (o.rsp_dat !== exp || o.rsp_err !== 1'b0) begin
                miscompares++; $display("FAIL rand_rsp_%0d got dat=%h err=%b exp %h/0", k, o.rsp_dat, o.rsp_err, exp);
            end
            vectors++;
            if (o.adr !== {2'b00, a[9:2]} || o.we !== we || o.sel !== s || o.dat !== d) begin
                miscompares++; $display("FAIL rand_bus_%0d got adr=%h we=%b sel=%h dat=%h exp %h/%b/%h/%h", k, o.adr, o.we, o.sel, o.dat, {2'b00, a[9:2]}, we, s, d);
            end
            vectors++;
            if (o.lat !== 3 || o.stb_len !== 2 || o.stable !== 1'b1 || o.ready_low !== 1'b1 || o.consumed !== 1'b1) begin
                miscompares++; $display("FAIL rand_timing_%0d got lat=%0d stb=%0d stable=%b rl=%b cons=%b exp 3/2/1/1/1", k, o.lat, o.stb_len, o.stable, o.ready_low, o.consumed);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_adr_i = '0;
        req_sel_i = '0; req_dat_i = '0; rsp_ready_i = 1'b0;
        slave_en = 1'b1; ack_delay = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_timeout();
        test_reset_mid_bus();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit got=expired exp=finish");
        $fatal(1, "time limit");
    end

endmodule
